// File: rtl/noc_input_buffer_if.sv
// noc_input_buffer_if: one valid/ready flit channel (flit, last, valid, ready).
// The master drives flit/last/valid and the slave drives ready.
interface noc_input_buffer_if #(
    parameter int unsigned FLIT_WIDTH = 32
);
    logic [FLIT_WIDTH-1:0] flit;
    logic                  last;
    logic                  valid;
    logic                  ready;

    modport master (
        output flit,
        output last,
        output valid,
        input  ready
    );

    modport slave (
        input  flit,
        input  last,
        input  valid,
        output ready
    );
endinterface

// File: rtl/noc_input_buffer.sv
// noc_input_buffer: per-channel flit FIFO feeding one input of the NoC output mux.
// It has DEPTH circular entries of {last, flit} and gives first-word fall-through
// from storage with no empty bypass. It also keeps a count of complete packets
// (tails) held.
// Optional macro NOC_INPUT_BUFFER_FULLPACKET_EN: the head is offered only while a
// whole packet is stored, or while the buffer is full. The full case releases
// packets longer than DEPTH.
module noc_input_buffer #(
    parameter int unsigned FLIT_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    noc_input_buffer_if.slave       in_ch,
    noc_input_buffer_if.master      out_ch,
    output logic [CNT_W-1:0]        fill_level,
    output logic [CNT_W-1:0]        packet_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef logic [FLIT_WIDTH:0] entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fill_q;
    logic [CNT_W-1:0] pkt_q;

    logic             full;
    logic             empty;
    logic             head_valid;
    logic             push;
    logic             pop;
    logic             push_tail;
    logic             pop_tail;
    entry_t           head;

    // Status derived purely from registered state
    always_comb begin
        full  = (fill_q == FULL_LVL);
        empty = (fill_q == '0);
    end

    // Head-valid qualification (packet-complete gating when enabled)
    always_comb begin
`ifdef NOC_INPUT_BUFFER_FULLPACKET_EN
        head_valid = (pkt_q != '0) | full;
`else
        head_valid = !empty;
`endif
    end

    // Handshakes and the tail flags that move packet_cnt
    always_comb begin
        head      = mem[rd_ptr];
        push      = in_ch.valid & !full;
        pop       = head_valid & out_ch.ready;
        push_tail = push & in_ch.last;
        pop_tail  = pop & head[FLIT_WIDTH];
    end

    // Channel outputs; head fields forced to zero while not valid
    always_comb begin
        in_ch.ready  = !full;
        out_ch.valid = head_valid;
        out_ch.flit  = '0;
        out_ch.last  = 1'b0;
        if (head_valid) begin
            out_ch.flit = head[FLIT_WIDTH-1:0];
            out_ch.last = head[FLIT_WIDTH];
        end
    end

    // Storage write on push; contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_ch.last, in_ch.flit};
        end
    end

    // Pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Flit occupancy: unchanged on simultaneous push and pop
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   fill_q <= fill_q + CNT_ONE;
                2'b01:   fill_q <= fill_q - CNT_ONE;
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Complete-packet count: tails in minus tails out
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_q <= '0;
        end else begin
            unique case ({push_tail, pop_tail})
                2'b10:   pkt_q <= pkt_q + CNT_ONE;
                2'b01:   pkt_q <= pkt_q - CNT_ONE;
                default: pkt_q <= pkt_q;
            endcase
        end
    end

    // Counter outputs
    always_comb begin
        fill_level = fill_q;
        packet_cnt = pkt_q;
    end

endmodule
